usb_rx_packet_ctrl: RTL and testbench



---
 rtl/usb_rx_pkg.sv | 35 +++
 rtl/usb_nrzi_shift.sv | 53 +++++
 rtl/usb_rx_packet_ctrl.sv | 167 ++++++++++++++++
 tb/tb_usb_rx_packet_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet controller.
// Holds the controller state encoding, the default SYNC pattern and byte limit,
// the PID codes, and a helper that checks the PID check-nibble.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC_WAIT,
        PID_WAIT,
        DATA_WAIT,
        EOP_WAIT,
        DONE,
        ERROR
    } rx_state_e;

    // KJKJKJKK after NRZI decode, LSB first.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
    localparam int         MAX_BYTES_DEF = 64;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // A PID byte carries its own check: upper nibble is the complement of the lower.
    function automatic logic pid_valid(input logic [7:0] b);
        return b[3:0] == ~b[7:4];
    endfunction

endpackage

// File: rtl/usb_nrzi_shift.sv
// NRZI decoder and LSB-first 8-bit deserializer with a 3-bit bit counter.
// Latency: sr_o/bit_cnt_o update on the clock after a shift strobe; no backpressure (strobe driven).
// Ports: clr_i re-arms for a new packet, shift_en_i samples d_i, sr_o/bit_cnt_o expose the shifter.
module usb_nrzi_shift (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr_i,
    input  logic       shift_en_i,
    input  logic       d_i,
    output logic [7:0] sr_o,
    output logic [2:0] bit_cnt_o
);

    logic       prev_q, prev_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       decoded;

    // NRZI: no transition is a 1, a transition is a 0.
    assign decoded = ~(d_i ^ prev_q);

    always_comb begin
        prev_d    = prev_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (clr_i) begin
            // The line idled at J before the packet's first transition, so the
            // decoder reference is J regardless of where the previous packet ended.
            prev_d    = 1'b1;
            bit_cnt_d = 3'd0;
        end else if (shift_en_i) begin
            prev_d    = d_i;
            sr_d      = {decoded, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev_q    <= 1'b1;
            sr_q      <= 8'hFF;
            bit_cnt_q <= 3'd0;
        end else begin
            prev_q    <= prev_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sr_o      = sr_q;
    assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet controller: SYNC/PID check, byte framing, FIFO writes, EOP handling.
// Latency: rx_data/w_enable one clock after byte_received; packet_done one clock after the J edge.
// Backpressure: none; the FIFO must accept every w_enable. Ports: line inputs, timer strobes, FIFO/status outputs.
module usb_rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int          MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    output logic       receiving,
    output logic [7:0] rx_data,
    output logic       w_enable,
    output logic [3:0] rx_pid,
    output logic       packet_done,
    output logic       r_error
);

    localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

    rx_state_e  state_q;
    logic [6:0] byte_cnt_q;
    logic       err_eop_q;      // ERROR has seen eop high and now waits for it to fall
    logic       receiving_q;
    logic [7:0] rx_data_q;
    logic       w_enable_q;
    logic [3:0] rx_pid_q;
    logic       packet_done_q;
    logic       r_error_q;

    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic       sync_start;

    assign sync_start = (state_q == IDLE) && d_edge;

    usb_nrzi_shift u_shift (
        .clk        (clk),
        .n_rst      (n_rst),
        .clr_i      (sync_start),
        .shift_en_i (shift_enable),
        .d_i        (d_plus_sync),
        .sr_o       (sr),
        .bit_cnt_o  (bit_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            byte_cnt_q    <= 7'd0;
            err_eop_q     <= 1'b0;
            receiving_q   <= 1'b0;
            rx_data_q     <= 8'h00;
            w_enable_q    <= 1'b0;
            rx_pid_q      <= 4'h0;
            packet_done_q <= 1'b0;
            r_error_q     <= 1'b0;
        end else begin
            w_enable_q    <= 1'b0;
            packet_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    byte_cnt_q <= 7'd0;
                    if (d_edge) begin
                        state_q     <= SYNC_WAIT;
                        receiving_q <= 1'b1;
                    end
                end
                SYNC_WAIT: begin
                    if (byte_received) begin
                        if (sr == SYNC_BYTE) begin
                            state_q   <= PID_WAIT;
                            r_error_q <= 1'b0;
                        end else begin
                            state_q   <= ERROR;
                            r_error_q <= 1'b1;
                            err_eop_q <= eop;
                        end
                    end else if (eop) begin
                        state_q   <= ERROR;
                        r_error_q <= 1'b1;
                        err_eop_q <= 1'b1;
                    end
                end
                PID_WAIT: begin
                    if (byte_received) begin
                        if (pid_valid(sr)) begin
                            rx_pid_q <= sr[3:0];
                            state_q  <= DATA_WAIT;
                        end else begin
                            state_q   <= ERROR;
                            r_error_q <= 1'b1;
                            err_eop_q <= eop;
                        end
                    end else if (eop) begin
                        state_q   <= ERROR;
                        r_error_q <= 1'b1;
                        err_eop_q <= 1'b1;
                    end
                end
                DATA_WAIT: begin
                    if (byte_received) begin
                        if (byte_cnt_q == MAX_CNT) begin
                            state_q   <= ERROR;
                            r_error_q <= 1'b1;
                            err_eop_q <= eop;
                        end else begin
                            rx_data_q  <= sr;
                            w_enable_q <= 1'b1;
                            byte_cnt_q <= byte_cnt_q + 7'd1;
                            // A byte completing together with SE0 still counts.
                            if (eop) begin
                                state_q <= EOP_WAIT;
                            end
                        end
                    end else if (eop) begin
                        if (bit_cnt == 3'd0) begin
                            state_q <= EOP_WAIT;
                        end else begin
                            state_q   <= ERROR;
                            r_error_q <= 1'b1;
                            err_eop_q <= 1'b1;
                        end
                    end
                end
                EOP_WAIT: begin
                    // SE0 ending and the J edge normally arrive together.
                    if (d_edge && !eop) begin
                        state_q       <= DONE;
                        packet_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q     <= IDLE;
                    receiving_q <= 1'b0;
                end
                ERROR: begin
                    if (eop) begin
                        err_eop_q <= 1'b1;
                    end else if (err_eop_q) begin
                        err_eop_q   <= 1'b0;
                        state_q     <= IDLE;
                        receiving_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    receiving_q <= 1'b0;
                end
            endcase
        end
    end

    assign receiving   = receiving_q;
    assign rx_data     = rx_data_q;
    assign w_enable    = w_enable_q;
    assign rx_pid      = rx_pid_q;
    assign packet_done = packet_done_q;
    assign r_error     = r_error_q;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Testbench for usb_rx_packet_ctrl: directed test-plan packets plus randomized packets.
// Expected writes, PID, error and done flags come from a packet-level model of the protocol rules.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_usb_rx_packet_ctrl;
    import usb_rx_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_plus_sync;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic       receiving;
    logic [7:0] rx_data;
    logic       w_enable;
    logic [3:0] rx_pid;
    logic       packet_done;
    logic       r_error;

    always #5 clk = ~clk;

    usb_rx_packet_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_plus_sync   (d_plus_sync),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .receiving     (receiving),
        .rx_data       (rx_data),
        .w_enable      (w_enable),
        .rx_pid        (rx_pid),
        .packet_done   (packet_done),
        .r_error       (r_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed FIFO writes and packet_done pulses.
    logic [7:0] obs_q[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (w_enable) obs_q.push_back(rx_data);
        if (packet_done) done_cnt++;
        if (w_enable || packet_done) chk("wen_done_excl", 32'(w_enable && packet_done), 32'd0);
    end

    // Line and packet description.
    logic       lvl;
    logic [7:0] pk_sync;
    logic [7:0] pk_pid;
    logic [7:0] pk_data[$];
    int         pk_npart;
    logic       pk_coinc;

    // Model state carried across packets.
    logic [7:0] exp_q[$];
    logic [3:0] exp_pid = 4'h0;
    logic       exp_err = 1'b0;
    logic       exp_done;

    task automatic drive_bit(input logic b, input logic first);
        logic nl;
        nl = b ? lvl : ~lvl;
        @(negedge clk);
        d_edge      = (nl != lvl) || first;
        d_plus_sync = nl;
        lvl         = nl;
        @(negedge clk);
        d_edge = 1'b0;
        @(negedge clk);
        shift_enable = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic first, input logic with_eop);
        for (int i = 0; i < 8; i++) drive_bit(b[i], first && (i == 0));
        @(negedge clk);
        byte_received = 1'b1;
        if (with_eop) begin
            eop         = 1'b1;
            d_plus_sync = 1'b0;
            lvl         = 1'b0;
        end
        @(negedge clk);
        byte_received = 1'b0;
    endtask

    task automatic finish_packet(input logic eop_already);
        if (!eop_already) begin
            @(negedge clk);
            eop         = 1'b1;
            d_plus_sync = 1'b0;
        end
        repeat (2) @(negedge clk);
        @(negedge clk);
        eop         = 1'b0;
        d_plus_sync = 1'b1;
        d_edge      = 1'b1;
        lvl         = 1'b1;
        @(negedge clk);
        d_edge = 1'b0;
        chk("packet_done_after_J", 32'(packet_done), 32'(exp_done));
        repeat (3) @(negedge clk);
    endtask

    // Packet-level reference: what a correct receiver reports for the described packet.
    task automatic model_packet();
        exp_q.delete();
        exp_done = 1'b0;
        if (pk_sync != 8'h80) begin
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            if ((pk_pid[3:0] ^ pk_pid[7:4]) != 4'hF) begin
                exp_err = 1'b1;
            end else begin
                exp_pid = pk_pid[3:0];
                for (int i = 0; i < pk_data.size() && i < 64; i++) exp_q.push_back(pk_data[i]);
                if (pk_data.size() > 64 || pk_npart != 0) exp_err = 1'b1;
                else exp_done = 1'b1;
            end
        end
    endtask

    task automatic run_packet();
        int last;
        model_packet();
        obs_q.delete();
        done_cnt = 0;
        last = pk_data.size() - 1;
        repeat (4) @(negedge clk);
        drive_byte(pk_sync, 1'b1, 1'b0);
        drive_byte(pk_pid, 1'b0, 1'b0);
        for (int i = 0; i < pk_data.size(); i++) drive_byte(pk_data[i], 1'b0, pk_coinc && (i == last));
        for (int j = 0; j < pk_npart; j++) drive_bit(1'($urandom_range(0, 1)), 1'b0);
        chk("receiving_mid", 32'(receiving), 32'd1);
        finish_packet(pk_coinc);
        chk("n_writes", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("wr_data[%0d]", i), 32'(obs_q[i]), 32'(exp_q[i]));
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("r_error", 32'(r_error), 32'(exp_err));
        chk("rx_pid", 32'(rx_pid), 32'(exp_pid));
        chk("receiving_end", 32'(receiving), 32'd0);
    endtask

    task automatic set_packet(input logic [7:0] s, input logic [7:0] p, input int nd, input int npart,
                              input logic coinc);
        pk_sync  = s;
        pk_pid   = p;
        pk_npart = npart;
        pk_coinc = coinc;
        pk_data.delete();
        for (int i = 0; i < nd; i++) pk_data.push_back(8'($urandom));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_receiving"}, 32'(receiving), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        chk({tag, "_w_enable"}, 32'(w_enable), 32'd0);
        chk({tag, "_rx_pid"}, 32'(rx_pid), 32'd0);
        chk({tag, "_packet_done"}, 32'(packet_done), 32'd0);
        chk({tag, "_r_error"}, 32'(r_error), 32'd0);
    endtask

    initial begin
        int         kind;
        logic [7:0] r;
        logic [3:0] nib;

        n_rst         = 1'b0;
        d_plus_sync   = 1'b1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        lvl           = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        n_rst = 1'b1;

        // ACK handshake: PID only.
        set_packet(8'h80, {~PID_ACK, PID_ACK}, 0, 0, 1'b0);
        run_packet();

        // DATA0 with two known bytes.
        set_packet(8'h80, 8'hC3, 0, 0, 1'b0);
        pk_data.push_back(8'hA5);
        pk_data.push_back(8'h3C);
        run_packet();

        // Corrupt SYNC, then a good packet clears the error.
        set_packet(8'h81, 8'hC3, 1, 0, 1'b0);
        run_packet();
        set_packet(8'h80, 8'h4B, 1, 0, 1'b0);
        run_packet();

        // Bad PID check nibble.
        set_packet(8'h80, 8'hC2, 2, 0, 1'b0);
        run_packet();

        // EOP inside a partial byte.
        set_packet(8'h80, 8'hC3, 2, 4, 1'b0);
        run_packet();

        // Last byte_received coincident with eop.
        set_packet(8'h80, 8'hC3, 1, 0, 1'b1);
        run_packet();

        // Overflow: one byte beyond the limit.
        set_packet(8'h80, 8'hC3, 65, 0, 1'b0);
        run_packet();

        // Reset in the middle of a DATA0 packet.
        obs_q.delete();
        repeat (4) @(negedge clk);
        drive_byte(8'h80, 1'b1, 1'b0);
        drive_byte(8'hC3, 1'b0, 1'b0);
        drive_byte(8'h5A, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) drive_bit(1'b0, 1'b0);
        chk("pre_reset_writes", 32'(obs_q.size()), 32'd1);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        d_plus_sync = 1'b1;
        lvl         = 1'b1;
        n_rst       = 1'b1;
        exp_pid     = 4'h0;
        exp_err     = 1'b0;
        set_packet(8'h80, 8'hC3, 3, 0, 1'b0);
        run_packet();

        // Randomized packets.
        for (int n = 0; n < 20; n++) begin
            kind = $urandom_range(0, 9);
            nib  = 4'($urandom);
            set_packet(8'h80, {~nib, nib}, $urandom_range(0, 6), 0, 1'b0);
            case (kind)
                0: begin
                    do r = 8'($urandom); while (r == 8'h80);
                    pk_sync = r;
                end
                1: begin
                    do r = 8'($urandom); while ((r[3:0] ^ r[7:4]) == 4'hF);
                    pk_pid = r;
                end
                2: pk_npart = $urandom_range(1, 7);
                3: begin
                    pk_coinc = 1'b1;
                    if (pk_data.size() == 0) pk_data.push_back(8'($urandom));
                end
                default: ;
            endcase
            run_packet();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
